// File: rtl/scrolling_block_drawer.sv
// Scrolling rectangular obstacle: holds its origin, steps it left on each screen update, and
// streams one pixel per clock over the block when the sequencer requests a draw.
module scrolling_block_drawer #(
  parameter int       WIDTH    = 8,
  parameter int       HEIGHT   = 8,
  parameter int       STEP     = 2,
  parameter int       START_X  = 160,
  parameter int       START_Y  = 100,
  parameter int       SCREEN_W = 160,
  parameter bit [2:0] COLOUR   = 3'b010
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        draw_start,
  input  logic        update_screen,
  output logic [10:0] send_x,
  output logic [10:0] send_y,
  output logic [2:0]  send_colour,
  output logic        plot,
  output logic        draw_done
);

  localparam logic [10:0] START_X_L  = 11'(START_X);
  localparam logic [10:0] START_Y_L  = 11'(START_Y);
  localparam logic [10:0] STEP_L     = 11'(STEP);
  localparam logic [10:0] SCREEN_W_L = 11'(SCREEN_W);
  localparam logic [10:0] W_LAST     = 11'(WIDTH - 1);
  localparam logic [10:0] H_LAST     = 11'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t      state, state_nxt;
  logic [10:0] origin_x, origin_x_nxt;
  logic [10:0] col, col_nxt, row, row_nxt;
  logic        pending, pending_nxt;
  logic [10:0] send_x_nxt, send_y_nxt;
  logic        plot_nxt, draw_done_nxt;
  logic [10:0] moved_x, pix_x;
  logic        last_pix;

  assign moved_x  = (origin_x < STEP_L) ? START_X_L : origin_x - STEP_L;
  assign pix_x    = origin_x + col;
  assign last_pix = (col == W_LAST) && (row == H_LAST);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // DONE is left only once draw_done has been shown for at least one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (draw_start) state_nxt = DRAW;
      DRAW:    if (last_pix) state_nxt = DONE;
      DONE:    if (draw_done && !draw_start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    origin_x_nxt  = origin_x;
    col_nxt       = col;
    row_nxt       = row;
    pending_nxt   = pending;
    send_x_nxt    = send_x;
    send_y_nxt    = send_y;
    plot_nxt      = 1'b0;
    draw_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (update_screen) begin
          if (draw_start) pending_nxt  = 1'b1;
          else            origin_x_nxt = moved_x;
        end
        if (draw_start) begin
          col_nxt = '0;
          row_nxt = '0;
        end
      end
      DRAW: begin
        send_x_nxt = pix_x;
        send_y_nxt = START_Y_L + row;
        plot_nxt   = (pix_x < SCREEN_W_L);
        if (update_screen) pending_nxt = 1'b1;
        if (col == W_LAST) begin
          col_nxt = '0;
          row_nxt = row + 11'd1;
        end else begin
          col_nxt = col + 11'd1;
        end
      end
      DONE: begin
        draw_done_nxt = 1'b1;
        if (update_screen) pending_nxt = 1'b1;
        if (draw_done && !draw_start) begin
          draw_done_nxt = 1'b0;
          pending_nxt   = 1'b0;
          if (pending || update_screen) origin_x_nxt = moved_x;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      origin_x    <= START_X_L;
      col         <= '0;
      row         <= '0;
      pending     <= 1'b0;
      send_x      <= START_X_L;
      send_y      <= START_Y_L;
      send_colour <= COLOUR;
      plot        <= 1'b0;
      draw_done   <= 1'b0;
    end else begin
      origin_x    <= origin_x_nxt;
      col         <= col_nxt;
      row         <= row_nxt;
      pending     <= pending_nxt;
      send_x      <= send_x_nxt;
      send_y      <= send_y_nxt;
      send_colour <= COLOUR;
      plot        <= plot_nxt;
      draw_done   <= draw_done_nxt;
    end
  end

endmodule
